// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshakes plus the simple_fifo write port shared through the arbiter.
// Latency: none, signal bundle only.
// Backpressure: req_rdy per requester; fifo_dat_cnt/fifo_wr_full report FIFO fullness.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]            req_rdy;
    logic                          fifo_wr_ena;
    logic [DATA_WIDTH-1:0]         fifo_wr_dat;
    logic                          fifo_wr_full;
    logic [ADDR_WIDTH:0]           fifo_dat_cnt;

    modport master (
        input  req_vld, req_dat, fifo_wr_full, fifo_dat_cnt,
        output req_rdy, fifo_wr_ena, fifo_wr_dat
    );

    modport slave (
        output req_vld, req_dat, fifo_wr_full, fifo_dat_cnt,
        input  req_rdy, fifo_wr_ena, fifo_wr_dat
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one simple_fifo write port among NUM_REQ producers, MAX_BURST beats per grant.
// Latency: vld sampled in IDLE -> rdy next cycle -> registered fifo_wr_ena one cycle after the transfer.
// Backpressure: rdy withheld unless the FIFO has room counting the in-flight write; a stalled grant is held.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_wr_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CW    = ID_W + 1;
    localparam int SW    = ADDR_WIDTH + 2;
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       last_id;
    logic [BW-1:0]         burst_cnt;
    logic [SW-1:0]         space;
    logic                  ok;
    logic                  vld_g;
    logic                  xfer;
    logic                  last_beat;
    logic                  any_vld;
    logic [ID_W-1:0]       pick;
    logic [DATA_WIDTH-1:0] sel_dat;

    // The in-flight registered write is not yet in dat_cnt, so subtract it too.
    assign space     = SW'(DEPTH) - SW'(bus.fifo_dat_cnt) - SW'(bus.fifo_wr_ena);
    assign ok        = !space[SW-1] && (space != '0) && !bus.fifo_wr_full;
    assign vld_g     = bus.req_vld[grant_id];
    assign xfer      = (state == GRANT) && vld_g && ok;
    assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));
    assign sel_dat   = bus.req_dat[grant_id*DATA_WIDTH +: DATA_WIDTH];

    // Scan from farthest to nearest so the requester right after last_id wins.
    always_comb begin
        logic [CW-1:0] idx;
        pick    = '0;
        any_vld = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = {1'b0, last_id} + CW'(k);
            if (idx >= CW'(NUM_REQ)) begin
                idx = idx - CW'(NUM_REQ);
            end
            if (bus.req_vld[idx[ID_W-1:0]]) begin
                pick    = idx[ID_W-1:0];
                any_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld) state_nxt = GRANT;
            GRANT:   if (!vld_g || (xfer && last_beat)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == GRANT);
        bus.req_rdy = '0;
        if ((state == GRANT) && ok) begin
            bus.req_rdy[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id        <= '0;
            burst_cnt       <= '0;
            last_id         <= ID_W'(NUM_REQ - 1);
            bus.fifo_wr_ena <= 1'b0;
            bus.fifo_wr_dat <= '0;
        end else begin
            bus.fifo_wr_ena <= xfer;
            if (xfer) begin
                bus.fifo_wr_dat <= sel_dat;
            end
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        grant_id  <= pick;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (state_nxt == IDLE) begin
                        last_id <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO occupancy model and a write scoreboard.
module tb_fifo_wr_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    logic       pop;
    logic       fifo_clr;
    int         fcnt = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.master),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // Occupancy model of simple_fifo: writes dropped when full, pops ignored when empty.
    always @(posedge clk) begin
        if (fifo_clr) fcnt <= 0;
        else fcnt <= fcnt + ((ifc.fifo_wr_ena && fcnt < DEPTH) ? 1 : 0) - ((pop && fcnt > 0) ? 1 : 0);
    end
    assign ifc.fifo_dat_cnt = 5'(fcnt);
    assign ifc.fifo_wr_full = (fcnt == DEPTH);

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  src[NR][$];
    logic [7:0]  exp_q[$];
    int          gseq[$];
    int          xt[NR][$];
    int          tick_no, nwr, first_wr, last_wr, nx, nx0, pop_left;
    logic        ovf, prev_busy, pop_always;
    logic [NR-1:0] obs_rdy;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < NR; i++) begin
            ifc.req_vld[i]           = (src[i].size() > 0);
            ifc.req_dat[i*DW +: DW]  = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
        pop = pop_always || (pop_left > 0);
    endfunction

    function automatic void clear_rec();
        exp_q.delete();
        gseq.delete();
        for (int i = 0; i < NR; i++) xt[i].delete();
        tick_no = 0; nwr = 0; first_wr = -1; last_wr = -1; nx = 0;
        ovf = 1'b0; prev_busy = 1'b0;
    endfunction

    // Observe on the falling edge, then update requesters just after the rising edge.
    task automatic tick();
        logic [NR-1:0] xf;
        logic [31:0]   e;
        @(negedge clk);
        tick_no++;
        obs_rdy = ifc.req_rdy;
        if (ifc.fifo_wr_ena) begin
            nwr++;
            if (first_wr < 0) first_wr = tick_no;
            last_wr = tick_no;
            e = 32'hFFFF_FFFF;
            if (exp_q.size() > 0) e = {24'h0, exp_q.pop_front()};
            chk("wr_dat", {24'h0, ifc.fifo_wr_dat}, e);
        end
        if (ifc.fifo_wr_ena && fcnt == DEPTH) ovf = 1'b1;
        if (busy && !prev_busy) gseq.push_back(int'(grant_id));
        prev_busy = busy;
        xf = ifc.req_vld & ifc.req_rdy;
        for (int i = 0; i < NR; i++) if (xf[i]) begin xt[i].push_back(tick_no); nx++; end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (xf[i]) void'(src[i].pop_front());
        drive();
        if (pop_left > 0) pop_left--;
    endtask

    task automatic run_until(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0; fifo_clr = 1'b1; pop_always = 1'b0; pop_left = 0;
        for (int i = 0; i < NR; i++) src[i].delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; fifo_clr = 1'b0;
        @(posedge clk);
        #1;
        clear_rec();
    endtask

    initial begin
        rst = 1'b0; fifo_clr = 1'b1; pop = 1'b0; pop_left = 0; pop_always = 1'b0;
        ifc.req_vld = '0; ifc.req_dat = '0;
        clear_rec();

        // Reset state
        do_reset();
        chk("rst_rdy", 32'(ifc.req_rdy), 0);
        chk("rst_wr_ena", 32'(ifc.fifo_wr_ena), 0);
        chk("rst_wr_dat", 32'(ifc.fifo_wr_dat), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single requester, 20 beats with a draining reader
        do_reset();
        pop_always = 1'b1;
        for (int k = 0; k < 20; k++) begin src[0].push_back(8'(k)); exp_q.push_back(8'(k)); end
        drive();
        run_until("p1_timeout", 200);
        chk("p1_first_wr_tick", 32'(first_wr), 3);
        chk("p1_nwr", 32'(nwr), 20);
        chk("p1_span", 32'(last_wr - first_wr + 1), 24);
        chk("p1_grants", 32'(gseq.size()), 5);

        // Round-robin fairness across all requesters
        do_reset();
        pop_always = 1'b1;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 8; k++) src[r].push_back(8'(r*16 + k));
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NR; r++)
                for (int j = 0; j < MB; j++) exp_q.push_back(8'(r*16 + b*MB + j));
        drive();
        run_until("p2_timeout", 300);
        chk("p2_grants", 32'(gseq.size()), 8);
        for (int g = 0; g < 8 && g < gseq.size(); g++) chk("p2_grant_order", 32'(gseq[g]), 32'(g % NR));
        chk("p2_span", 32'(last_wr - first_wr + 1), 39);

        // Full backpressure, then three pops
        do_reset();
        for (int k = 0; k < 20; k++) src[1].push_back(8'(100 + k));
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(100 + k));
        drive();
        repeat (40) tick();
        chk("p3_nwr_full", 32'(nwr), 16);
        chk("p3_cnt_full", 32'(fcnt), 16);
        chk("p3_wr_full", 32'(ifc.fifo_wr_full), 1);
        chk("p3_rdy_stalled", 32'(obs_rdy), 0);
        for (int k = 16; k < 19; k++) exp_q.push_back(8'(100 + k));
        pop_left = 3;
        repeat (20) tick();
        chk("p3_nwr_after_pop", 32'(nwr), 19);
        chk("p3_src_left", 32'(src[1].size()), 1);
        chk("p3_cnt_refill", 32'(fcnt), 16);
        chk("p3_no_overflow", 32'(ovf), 0);

        // Space boundary: one free slot, exactly one beat fits
        do_reset();
        for (int k = 0; k < 15; k++) begin src[0].push_back(8'(k)); exp_q.push_back(8'(k)); end
        drive();
        run_until("p4_fill_timeout", 100);
        chk("p4_cnt15", 32'(fcnt), 15);
        nx0 = nx;
        for (int k = 0; k < 3; k++) src[0].push_back(8'(8'hE0 + k));
        exp_q.push_back(8'hE0);
        drive();
        tick();
        tick();
        chk("p4_rdy_last_slot", 32'(obs_rdy), 32'h1);
        tick();
        chk("p4_rdy_inflight", 32'(obs_rdy), 0);
        repeat (8) tick();
        chk("p4_one_beat", 32'(nx - nx0), 1);
        chk("p4_cnt16", 32'(fcnt), 16);
        chk("p4_no_overflow", 32'(ovf), 0);
        chk("p4_exp_drained", 32'(exp_q.size()), 0);

        // Early drop of vld moves the grant on with a fresh burst count
        do_reset();
        pop_always = 1'b1;
        src[2].push_back(8'hA0); src[2].push_back(8'hA1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        for (int k = 0; k < 5; k++) begin src[3].push_back(8'(8'hB0 + k)); exp_q.push_back(8'(8'hB0 + k)); end
        drive();
        run_until("p5_timeout", 100);
        chk("p5_grants", 32'(gseq.size()), 3);
        if (gseq.size() == 3) begin
            chk("p5_grant0", 32'(gseq[0]), 2);
            chk("p5_grant1", 32'(gseq[1]), 3);
            chk("p5_grant2", 32'(gseq[2]), 3);
        end
        chk("p5_xfers", 32'(xt[2].size() + xt[3].size()), 7);
        if (xt[2].size() == 2 && xt[3].size() == 5) begin
            chk("p5_handover_gap", 32'(xt[3][0] - xt[2][1]), 3);
            chk("p5_full_burst", 32'(xt[3][3] - xt[3][0]), 3);
        end

        // Asynchronous reset in the middle of a burst
        do_reset();
        pop_always = 1'b1;
        for (int k = 0; k < 10; k++) src[3].push_back(8'(8'h30 + k));
        exp_q.push_back(8'h30);
        drive();
        repeat (3) tick();
        chk("p6_wr_before_rst", 32'(ifc.fifo_wr_ena), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("p6_rst_wr_ena", 32'(ifc.fifo_wr_ena), 0);
        chk("p6_rst_rdy", 32'(ifc.req_rdy), 0);
        chk("p6_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        gseq.delete();
        prev_busy = 1'b0;
        src[0].push_back(8'h5A);
        exp_q.delete();
        exp_q.push_back(8'h5A);
        for (int k = 0; k < src[3].size(); k++) exp_q.push_back(src[3][k]);
        chk("p6_src3_left", 32'(src[3].size()), 8);
        drive();
        run_until("p6_timeout", 100);
        chk("p6_grants", 32'(gseq.size()), 3);
        if (gseq.size() >= 2) begin
            chk("p6_first_after_rst", 32'(gseq[0]), 0);
            chk("p6_second_after_rst", 32'(gseq[1]), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets NUM_REQ producers share one simple_fifo write port.
- Each producer uses a valid/ready handshake. The block drives the FIFO's wr_ena/wr_dat from a register and uses dat_cnt to make sure it never writes into a full FIFO.
- Bursts are limited to MAX_BURST beats per grant so one producer cannot starve the others.
- Sits directly in front of simple_fifo. The FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, data width; must match the FIFO.
- ADDR_WIDTH, 4, FIFO address width; FIFO depth DEPTH = 2^ADDR_WIDTH.
- MAX_BURST, 4, maximum beats per grant (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- req_vld  in  NUM_REQ  per-requester valid.
- req_dat  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_rdy  out  NUM_REQ  per-requester ready; a beat transfers when req_vld[i] && req_rdy[i].
- fifo_wr_ena  out  1  registered FIFO write enable.
- fifo_wr_dat  out  DATA_WIDTH  registered FIFO write data.
- fifo_wr_full  in  1  FIFO full flag.
- fifo_dat_cnt  in  ADDR_WIDTH+1  FIFO occupancy.
- grant_id  out  clog2(NUM_REQ)  currently granted requester.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_rdy=0, fifo_wr_ena=0, fifo_wr_dat=0, grant_id=0, busy=0, burst_cnt=0, last_id=NUM_REQ-1. With last_id=NUM_REQ-1, requester 0 has top priority after reset.
- Reset asserted mid-burst:
  - Any beat not yet registered is dropped.
  - The registered beat is cleared: fifo_wr_ena goes to 0 immediately.
- space = DEPTH - fifo_dat_cnt - fifo_wr_ena, computed in ADDR_WIDTH+2 bits.
  - The subtraction accounts for the write still in flight.
  - ok = (space > 0) && !fifo_wr_full.
  - Reads from the FIFO are ignored, so the check is conservative.
- req_rdy[i] = (state==GRANT) && (grant_id==i) && ok. This is combinational. All other bits are 0.
- Transfer at edge t: at t+1, fifo_wr_ena=1 and fifo_wr_dat = that requester's data. Otherwise fifo_wr_ena=0 and fifo_wr_dat holds its value.
- IDLE:
  - If any req_vld is set, grant_id <= the first requester with vld set, searching circularly from last_id+1.
  - Then burst_cnt <= 0 and state goes to GRANT.
  - No ready is given in IDLE.
- GRANT:
  - Each transfer increments burst_cnt.
  - Exit to IDLE, with last_id <= grant_id, on either of these:
    - a transfer that makes burst_cnt reach MAX_BURST;
    - a cycle where req_vld[grant_id]=0.
  - While ok=0 and vld stays high, the grant is held (stall) and burst_cnt does not change.
- Latency:
  - vld rising in IDLE at edge t gives req_rdy at t+1 and fifo_wr_ena at t+2.
  - Each re-arbitration costs one IDLE bubble cycle.
- Requesters must hold req_dat stable while vld && !rdy. A requester may drop vld at any time before the transfer.
- Simultaneous requests: the circular order from last_id+1 decides. After a requester is served, it has the lowest priority.
- NUM_REQ=1 is not supported.

Test Plan:
- Single requester, 20 beats:
  - Stimulus: req 0 sends values 0..19 with vld held high; an external pop drains the FIFO.
  - Expected: FIFO receives 0..19 in order.
  - Expected: a one-cycle IDLE gap occurs every 4 beats (MAX_BURST=4).
  - Expected: fifo_wr_ena first rises 2 cycles after vld.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold vld. Each requester sends its id*16+k for k = 0..7.
  - Expected grant order: 0,1,2,3,0,1,2,3, with 4 beats each.
  - Expected pop sequence starts 0,1,2,3,16,17,18,19,32.
- Full backpressure:
  - Stimulus: req 1 pushes 20 beats with no reads.
  - Expected: exactly 16 writes accepted; req_rdy stays 0 after that; wr_full=1.
  - Expected: fifo_wr_ena never asserts while dat_cnt=16.
  - Then pop 3: exactly 3 more beats are accepted.
- Space boundary:
  - Stimulus: fill the FIFO to dat_cnt=15 and hold req vld.
  - Expected: exactly one beat is accepted, and rdy is 0 the next cycle (fifo_wr_ena counted in space).
- Early drop:
  - Stimulus: req 2 sends 2 beats, then drops vld while req 3 holds vld.
  - Expected: grant moves to 3 after one IDLE cycle; burst_cnt restarts.
- Reset mid-burst:
  - Stimulus: assert rst=0 asynchronously during a beat between clock edges.
  - Expected: fifo_wr_ena=0 and req_rdy=0 immediately.
  - Expected: after release, requester 0 wins first even if requester 3 was granted before reset.
